// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM state and ALU opcode mnemonics.
package alu_arbiter_pkg;

  typedef enum logic {IDLE, RESP} arb_state_e;

  // ALU opcode encoding; codes outside this list make the ALU output 0.
  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_NEG = 4'h6,
    OP_EQ  = 4'h7,
    OP_LT  = 4'h8,
    OP_SHL = 4'h9,
    OP_SHR = 4'hA
  } op_mne;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant with a single priority pointer (0 favours req[0]).
module rr_arb2 (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // After any grant the other requester becomes favoured.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)  ptr <= 1'b0;
    else if (|gnt) ptr <= gnt[0];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grant and a registered result.
// Optional per-requester grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W     = 8,
  parameter int Ops   = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [1:0]       ReqValid,
  output logic [1:0]       ReqReady,
  input  logic [W-1:0]     Req0A,
  input  logic [W-1:0]     Req0B,
  input  logic [Ops-1:0]   Req0Op,
  input  logic [W-1:0]     Req1A,
  input  logic [W-1:0]     Req1B,
  input  logic [Ops-1:0]   Req1Op,
  output logic [1:0]       RspValid,
  input  logic [1:0]       RspReady,
  output logic [W-1:0]     Result,
  output logic             RspZero,
  output logic             RspParity,
  output logic [W-1:0]     AluA,
  output logic [W-1:0]     AluB,
  output logic [Ops-1:0]   AluOp,
  input  logic [W-1:0]     AluOut
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] GrantCnt0,
  output logic [CNT_W-1:0] GrantCnt1
`endif
);

  arb_state_e            state;
  logic                  owner;
  logic                  en;
  logic [1:0]            gnt;
  logic [1:0][W-1:0]     opa, opb;
  logic [1:0][Ops-1:0]   opc;

  // Reset_n gates the grant so ReqReady/Alu* read 0 while reset is held.
  assign en = Reset_n && ((state == IDLE) || RspReady[owner]);

  rr_arb2 u_rr (
    .gclk   (Clk),
    .grst_n (Reset_n),
    .req    (ReqValid),
    .en     (en),
    .gnt    (gnt)
  );

  assign ReqReady = gnt;
  assign opa = {Req1A, Req0A};
  assign opb = {Req1B, Req0B};
  assign opc = {Req1Op, Req0Op};

  always_comb begin
    AluA  = '0;
    AluB  = '0;
    AluOp = '0;
    for (int i = 0; i < 2; i++) begin
      if (gnt[i]) begin
        AluA  = opa[i];
        AluB  = opb[i];
        AluOp = opc[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      Result    <= '0;
      RspZero   <= 1'b0;
      RspParity <= 1'b0;
    end else if (|gnt) begin
      state     <= RESP;
      owner     <= gnt[1];
      Result    <= AluOut;
      RspZero   <= (AluOut == '0);
      RspParity <= ^AluOut;
    end else if (state == RESP && RspReady[owner]) begin
      state     <= IDLE;
    end
  end

  assign RspValid = (state == RESP) ? {owner, ~owner} : 2'b00;

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      GrantCnt0 <= '0;
      GrantCnt1 <= '0;
    end else begin
      if (gnt[0] && GrantCnt0 != '1) GrantCnt0 <= GrantCnt0 + CNT_W'(1);
      if (gnt[1] && GrantCnt1 != '1) GrantCnt1 <= GrantCnt1 + CNT_W'(1);
    end
  end
`else
  // CNT_W only sizes the optional counters.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU hooked to AluA/AluB/AluOp/AluOut.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [1:0] ReqValid, ReqReady, RspValid, RspReady;
  logic [7:0] Req0A, Req0B, Req1A, Req1B, Result, AluA, AluB, AluOut;
  logic [3:0] Req0Op, Req1Op, AluOp;
  logic       RspZero, RspParity;
`ifdef ALU_ARB_STATS_EN
  logic [1:0] GrantCnt0, GrantCnt1;
`endif

  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  alu_arbiter #(.W(8), .Ops(4), .CNT_W(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .Req0A(Req0A), .Req0B(Req0B), .Req0Op(Req0Op),
    .Req1A(Req1A), .Req1B(Req1B), .Req1Op(Req1Op),
    .RspValid(RspValid), .RspReady(RspReady),
    .Result(Result), .RspZero(RspZero), .RspParity(RspParity),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluOut(AluOut)
`ifdef ALU_ARB_STATS_EN
    , .GrantCnt0(GrantCnt0), .GrantCnt1(GrantCnt1)
`endif
  );

  // Behavioural ALU
  always_comb begin
    case (AluOp)
      OP_ADD:  AluOut = AluA + AluB;
      OP_SUB:  AluOut = AluA - AluB;
      OP_AND:  AluOut = AluA & AluB;
      OP_OR:   AluOut = AluA | AluB;
      OP_XOR:  AluOut = AluA ^ AluB;
      OP_NOT:  AluOut = ~AluA;
      OP_NEG:  AluOut = 8'h00 - AluA;
      OP_EQ:   AluOut = (AluA == AluB) ? 8'h01 : 8'h00;
      OP_LT:   AluOut = (AluA < AluB) ? 8'h01 : 8'h00;
      OP_SHL:  AluOut = AluA << 1;
      OP_SHR:  AluOut = AluA >> 1;
      default: AluOut = 8'h00;
    endcase
  end

  task automatic clear_inputs();
    ReqValid = 2'b00; RspReady = 2'b00;
    Req0A = 8'h00; Req0B = 8'h00; Req0Op = 4'h0;
    Req1A = 8'h00; Req1B = 8'h00; Req1Op = 4'h0;
  endtask

  task automatic apply_reset();
    Reset_n = 1'b0;
    clear_inputs();
    @(posedge Clk); #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    clear_inputs();
    ReqValid = 2'b11;
    @(posedge Clk); #1;
    total++; if (RspValid !== 2'b00) begin bad++; $display("FAIL reset_rspvalid got=%b exp=00", RspValid); end
    total++; if (Result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h exp=00", Result); end
    total++; if ({RspZero, RspParity} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {RspZero, RspParity}); end
    total++; if (ReqReady !== 2'b00) begin bad++; $display("FAIL reset_reqready got=%b exp=00", ReqReady); end
    total++; if ({AluA, AluB, AluOp} !== 20'h0) begin bad++; $display("FAIL reset_alu got=%h exp=0", {AluA, AluB, AluOp}); end
    Reset_n = 1'b1;
    ReqValid = 2'b00;
  endtask

  task automatic test_single();
    apply_reset();
    ReqValid = 2'b01; Req0A = 8'h05; Req0B = 8'h03; Req0Op = OP_ADD; RspReady = 2'b01;
    #1;
    total++; if (ReqReady !== 2'b01) begin bad++; $display("FAIL single_reqready got=%b exp=01", ReqReady); end
    total++; if ({AluA, AluB, AluOp} !== {8'h05, 8'h03, 4'h0}) begin bad++; $display("FAIL single_alu got=%h exp=05030", {AluA, AluB, AluOp}); end
    @(posedge Clk); #1;
    ReqValid = 2'b00;
    total++; if (RspValid !== 2'b01) begin bad++; $display("FAIL single_rspvalid got=%b exp=01", RspValid); end
    total++; if (Result !== 8'h08) begin bad++; $display("FAIL single_result got=%h exp=08", Result); end
    total++; if (RspZero !== 1'b0) begin bad++; $display("FAIL single_zero got=%b exp=0", RspZero); end
    @(posedge Clk); #1;
    total++; if (RspValid !== 2'b00) begin bad++; $display("FAIL single_drain got=%b exp=00", RspValid); end
  endtask

  task automatic test_contention();
    apply_reset();
    ReqValid = 2'b11; RspReady = 2'b11;
    Req0A = 8'h01; Req0B = 8'h01; Req0Op = OP_ADD;
    Req1A = 8'h09; Req1B = 8'h04; Req1Op = OP_SUB;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_oh;
      logic [7:0] exp_res;
      exp_oh  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_res = (k % 2 == 0) ? 8'h02 : 8'h05;
      #1;
      total++; if (ReqReady !== exp_oh) begin bad++; $display("FAIL contention_grant%0d got=%b exp=%b", k, ReqReady, exp_oh); end
      @(posedge Clk); #1;
      total++; if (RspValid !== exp_oh || Result !== exp_res) begin
        bad++; $display("FAIL contention_rsp%0d got=%b/%h exp=%b/%h", k, RspValid, Result, exp_oh, exp_res);
      end
    end
    ReqValid = 2'b00;
  endtask

  task automatic test_backpressure();
    apply_reset();
    ReqValid = 2'b10; Req1A = 8'h10; Req1B = 8'h10; Req1Op = OP_EQ; RspReady = 2'b00;
    #1;
    total++; if (ReqReady !== 2'b10) begin bad++; $display("FAIL bp_grant got=%b exp=10", ReqReady); end
    @(posedge Clk); #1;
    ReqValid = 2'b01; Req0A = 8'h01; Req0B = 8'h02; Req0Op = OP_ADD;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (ReqReady !== 2'b00) begin bad++; $display("FAIL bp_reqready%0d got=%b exp=00", k, ReqReady); end
      total++; if (RspValid !== 2'b10 || Result !== 8'h01) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%h exp=10/01", k, RspValid, Result);
      end
      @(posedge Clk); #1;
    end
    RspReady = 2'b01;  // non-owner ready must be ignored
    #1;
    total++; if (ReqReady !== 2'b00) begin bad++; $display("FAIL bp_nonowner_ready got=%b exp=00", ReqReady); end
    @(posedge Clk); #1;
    total++; if (RspValid !== 2'b10 || Result !== 8'h01) begin bad++; $display("FAIL bp_nonowner_hold got=%b/%h exp=10/01", RspValid, Result); end
    RspReady = 2'b10;
    #1;
    total++; if (ReqReady !== 2'b01) begin bad++; $display("FAIL bp_b2b_grant got=%b exp=01", ReqReady); end
    @(posedge Clk); #1;
    ReqValid = 2'b00;
    total++; if (RspValid !== 2'b01 || Result !== 8'h03) begin bad++; $display("FAIL bp_b2b_rsp got=%b/%h exp=01/03", RspValid, Result); end
  endtask

  task automatic test_flags();
    apply_reset();
    RspReady = 2'b01; ReqValid = 2'b01;
    Req0A = 8'hFF; Req0B = 8'h01; Req0Op = OP_ADD;
    @(posedge Clk); #1;
    total++; if ({Result, RspZero, RspParity} !== {8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL flags_wrap got=%h/%b/%b exp=00/1/0", Result, RspZero, RspParity);
    end
    Req0A = 8'h01; Req0B = 8'h00; Req0Op = OP_NEG;
    @(posedge Clk); #1;
    total++; if ({Result, RspZero, RspParity} !== {8'hFF, 1'b0, 1'b0}) begin
      bad++; $display("FAIL flags_neg got=%h/%b/%b exp=ff/0/0", Result, RspZero, RspParity);
    end
    Req0A = 8'h07; Req0B = 8'h00; Req0Op = OP_XOR;
    @(posedge Clk); #1;
    total++; if ({Result, RspZero, RspParity} !== {8'h07, 1'b0, 1'b1}) begin
      bad++; $display("FAIL flags_parity got=%h/%b/%b exp=07/0/1", Result, RspZero, RspParity);
    end
    Req0A = 8'h05; Req0B = 8'h05; Req0Op = 4'hF;
    @(posedge Clk); #1;
    ReqValid = 2'b00;
    total++; if ({Result, RspZero} !== {8'h00, 1'b1}) begin
      bad++; $display("FAIL flags_undef_op got=%h/%b exp=00/1", Result, RspZero);
    end
  endtask

  task automatic test_reset_mid_resp();
    apply_reset();
    ReqValid = 2'b01; Req0A = 8'h02; Req0B = 8'h03; Req0Op = OP_ADD; RspReady = 2'b00;
    @(posedge Clk); #1;
    total++; if (RspValid !== 2'b01 || Result !== 8'h05) begin bad++; $display("FAIL midrst_pre got=%b/%h exp=01/05", RspValid, Result); end
    Reset_n = 1'b0;
    #1;
    total++; if (RspValid !== 2'b00 || Result !== 8'h00) begin bad++; $display("FAIL midrst_async got=%b/%h exp=00/00", RspValid, Result); end
    total++; if (ReqReady !== 2'b00 || AluA !== 8'h00) begin bad++; $display("FAIL midrst_comb got=%b/%h exp=00/00", ReqReady, AluA); end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    ReqValid = 2'b11; Req1Op = OP_ADD;
    #1;
    total++; if (ReqReady !== 2'b01) begin bad++; $display("FAIL midrst_ptr got=%b exp=01", ReqReady); end
    @(posedge Clk); #1;
    ReqValid = 2'b00;
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    ReqValid = 2'b01; RspReady = 2'b01; Req0A = 8'h01; Req0B = 8'h01; Req0Op = OP_ADD;
    repeat (2) @(posedge Clk);
    #1;
    total++; if (GrantCnt0 !== 2'b10) begin bad++; $display("FAIL stats_mid got=%b exp=10", GrantCnt0); end
    repeat (3) @(posedge Clk);
    #1;
    ReqValid = 2'b00;
    @(posedge Clk); #1;
    total++; if (GrantCnt0 !== 2'b11) begin bad++; $display("FAIL stats_sat got=%b exp=11", GrantCnt0); end
    total++; if (GrantCnt1 !== 2'b00) begin bad++; $display("FAIL stats_cnt1 got=%b exp=00", GrantCnt1); end
  endtask
`endif

  initial begin
    Reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flags();
    test_reset_mid_resp();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
